tribus_arbiter: RTL

Round-robin arbiter that shares one tristate bus among N requesters by sequencing the EN inputs of their TRIBUF drivers. At most one GNT bit is high at any time. A forced all-off turnaround gap separates every change of owner, so two drivers are never enabled together. The block sits beside the TRIBUF column in the synthesized netlist, with one GNT bit driving one TRIBUF EN.

---
 rtl/tribus_arbiter_pkg.sv | 16 +
 rtl/tribus_arbiter_rr_pick.sv | 25 ++
 rtl/tribus_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/tribus_arbiter_pkg.sv
// tribus_arbiter_pkg: FSM state encoding and register-width helper shared by the
// tribus arbiter and its round-robin picker.
package tribus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    // Width needed to hold values 0..v-1, never narrower than one bit.
    function automatic int width_of(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set request at or after
// (last+1) mod N, wrapping around.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Scan from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (i_req[IW'((int'(i_last) + k) % N)]) begin
                o_idx   = IW'((int'(i_last) + k) % N);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin owner sequencing for a shared tristate bus, with a
// hold limit, preemption and an all-off turnaround gap between owners.
module tribus_arbiter
    import tribus_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN     = 1,
    localparam int IW      = width_of(N),
    localparam int HW      = width_of(MAX_HOLD + 1)
) (
    input  logic          C,
    input  logic          R,
    input  logic [N-1:0]  REQ,
    output logic [N-1:0]  GNT,
    output logic [IW-1:0] OWNER,
    output logic          BUSY,
    output logic          PRE
);

    localparam int GW = width_of(TURN + 1);

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic [IW-1:0] r_owner, r_last, w_pick;
    logic [HW-1:0] r_hold;
    logic [GW-1:0] r_gap;
    logic          r_busy, w_pick_vld, w_load, w_others, w_at_limit, w_gap_done;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_req  (REQ),
        .i_last (r_last),
        .o_idx  (w_pick),
        .o_valid(w_pick_vld)
    );

    assign w_others   = |(REQ & ~(N'(1) << r_owner));
    assign w_at_limit = r_hold == HW'(MAX_HOLD);
    assign w_gap_done = r_gap == GW'(TURN);

    // A release wins over a coincident preemption, so PRE needs the owner still requesting.
    always_comb begin
        w_state_nxt = IDLE;
        w_load      = 1'b0;
        PRE         = 1'b0;
        case (r_state)
            IDLE: begin
                w_load      = w_pick_vld;
                w_state_nxt = w_pick_vld ? GRANT : IDLE;
            end
            GRANT: begin
                PRE         = REQ[r_owner] && w_at_limit && w_others;
                w_state_nxt = (!REQ[r_owner] || PRE) ? GAP : GRANT;
            end
            GAP: begin
                w_load      = w_gap_done && w_pick_vld;
                w_state_nxt = !w_gap_done ? GAP : (w_pick_vld ? GRANT : IDLE);
            end
            default: ;
        endcase
        w_gnt_nxt = w_load ? N'(1) << w_pick : (w_state_nxt == GRANT ? r_gnt : '0);
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_last  <= IW'(N - 1);
            r_hold  <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= |w_gnt_nxt;
            r_owner <= w_load ? w_pick : r_owner;
            r_last  <= w_load ? w_pick : r_last;
            r_hold  <= w_load ? HW'(1) : (w_state_nxt != GRANT ? '0 : (w_at_limit ? r_hold : r_hold + 1'b1));
            r_gap   <= w_state_nxt != GAP ? '0 : (r_state == GAP ? r_gap + 1'b1 : GW'(1));
        end
    end

    assign GNT   = r_gnt;
    assign OWNER = r_owner;
    assign BUSY  = r_busy;

endmodule
